lsu_subword_rmw: RTL and testbench
==================================

Name: lsu_subword_rmw

Overview:
- Load/store requester sitting between the core's MEM stage and the word-only data memory.
- Accepts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives a word-aligned, full-word memory port.
- Extracts and sign/zero-extends sub-word loads.
- Implements SB/SH as read-modify-write, because the memory port writes only whole words.

Parameters:
- DM_ADDRESS, 9, byte-address width presented to memory.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- MemRead  in  1  load request, from control unit.
- MemWrite  in  1  store request, from control unit.
- Funct3  in  3  instruction bits 14:12.
- addr  in  DM_ADDRESS  byte address.
- wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal request.
- rdata  out  DATA_W  extended load result; 0 for stores and errors.
- mem_addr  out  DM_ADDRESS  word-aligned address {addr[8:2],2'b00}.
- mem_re  out  1  memory read strobe.
- mem_Wr  out  4  write enable, 4'b0000 or 4'b1111 only.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after mem_re.

Behaviour:
- States: IDLE, RD, DATA, WR, RESP.
- Reset (async, rst_n=0):
  - state=IDLE.
  - resp_valid=0, resp_err=0, rdata=0.
  - mem_re=0, mem_Wr=4'b0000, mem_addr=0, mem_wdata=0.
  - req_ready=1 once in IDLE.
- Reset mid-operation aborts immediately:
  - mem_Wr drops to 0 asynchronously, so no partial write is issued.
  - No response is issued for the aborted request.
- Accept rule:
  - A request is accepted on a rising edge with req_valid && req_ready && (MemRead || MemWrite).
  - On accept, Funct3, addr, wdata and op are latched.
  - req_valid with neither MemRead nor MemWrite is not accepted and is ignored.
- Error detection at accept; on error the next state is RESP with resp_err=1 and no memory access. Errors are:
  - MemRead && MemWrite both set.
  - Load Funct3 in {011,110,111}.
  - Store Funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Sequencing from IDLE (accept at edge T):
  - Load or SB/SH: RD at T+1, mem_re=1 for exactly one cycle. DATA at T+2 samples mem_rdata.
    - Load: register extracted result, go to RESP at T+3.
    - SB/SH: merge and go to WR at T+3, then RESP at T+4.
  - SW: WR at T+1, mem_Wr=4'b1111, mem_wdata=wdata. RESP at T+2.
  - Error: RESP at T+1.
- RESP: resp_valid=1 for exactly one cycle, no backpressure, then IDLE.
  - A new request can be accepted at the edge that leaves RESP+1 (the next IDLE cycle).
- mem_addr holds the latched aligned address in RD, DATA and WR; in IDLE and RESP it holds its last value.
- Load extraction, with b = addr[1:0] and word = mem_rdata:
  - LB: sign-extend word[8b+7:8b].
  - LBU: zero-extend the same byte.
  - LH: sign-extend word[16·addr[1]+15 : 16·addr[1]].
  - LHU: zero-extend the same halfword.
  - LW: word.
- Store merge:
  - SB replaces byte lane b of mem_rdata with wdata[7:0].
  - SH replaces halfword lane addr[1] with wdata[15:0].
  - All other lanes are preserved bit-exact.
- rdata holds its value until the next response. It is overwritten with 0 for store and error responses.
- mem_Wr is nonzero only in WR. mem_re is high only in RD. They are never both high.

Test Plan:
- Reset, then SW addr=0x010 wdata=0xDEADBEEF → mem_Wr=1111 at T+1, mem_addr=0x010; resp_valid at T+2, resp_err=0, rdata=0.
- LB addr=0x013 with mem word 0x80FF7F01 → mem_re at T+1, mem_addr=0x010; rdata=0xFFFFFF80 at T+3. LBU same address → rdata=0x00000080.
- SB addr=0x011 wdata=0x000000AB over word 0x11223344 → mem_re T+1, mem_Wr=1111 T+3 with mem_wdata=0x1122AB44, resp at T+4.
- SH addr=0x012 wdata=0x0000CAFE over 0x11223344 → mem_wdata=0xCAFE3344. LH addr=0x012 afterwards → rdata=0xFFFFCAFE.
- Misaligned LW addr=0x006 and SH addr=0x005 → resp_valid=1 and resp_err=1 at T+1; mem_re=0 and mem_Wr=0 throughout.
- rst_n pulled low during the RD of an SB → mem_Wr never asserts, no resp_valid; memory word unchanged on re-read; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_subword_rmw_if.sv
// Request/response and word-memory bus for the sub-word load/store unit.
// slave  : the LSU itself.
// master : the core + data memory side (testbench).
interface lsu_subword_rmw_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_W-1:0]     rdata;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_re;
  logic [3:0]            mem_Wr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, rdata, mem_addr, mem_re, mem_Wr, mem_wdata
  );

  modport master (
    output req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, rdata, mem_addr, mem_re, mem_Wr, mem_wdata
  );
endinterface

// File: rtl/lsu_subword_rmw.sv
// RV32I load/store requester in front of a word-only data memory.
// Sub-word loads are extracted and extended; SB/SH are done as a
// read-modify-write because the memory can only write whole words.
// Only DATA_W = 32 is supported (lane logic is written for 4 bytes).
module lsu_subword_rmw #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_subword_rmw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            boff_q, boff_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  store_q, store_d;
  logic                  err_q, err_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  accept, req_err, f3_bad, misal;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_W-1:0]     load_ext, merged;

  // Accept qualification and legality of the incoming request
  always_comb begin
    accept = (state_q == IDLE) && bus.req_valid && (bus.MemRead || bus.MemWrite);
    f3_bad = 1'b0;
    if (bus.MemRead && bus.MemWrite)
      f3_bad = 1'b1;
    else if (bus.MemRead)
      f3_bad = (bus.Funct3 == 3'b011) || (bus.Funct3[2:1] == 2'b11);
    else
      f3_bad = (bus.Funct3 > 3'b010);
    // size is encoded in Funct3[1:0]: 01 halfword, 10 word
    misal = ((bus.Funct3[1:0] == 2'b01) && bus.addr[0]) ||
            ((bus.Funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    req_err = f3_bad || misal;
  end

  // Load lane extraction and store lane merge on the returned word
  always_comb begin
    ld_byte = bus.mem_rdata[{boff_q, 3'b000} +: 8];
    ld_half = boff_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'b0, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if ((f3_q[1:0] == 2'b00) && (boff_q == 2'(i)))
        merged[8*i +: 8] = wdata_q[7:0];
      if ((f3_q[1:0] == 2'b01) && (boff_q[1] == i[1]))
        merged[8*i +: 8] = wdata_q[8*(i%2) +: 8];
    end
  end

  // FSM next state: SW skips the read, sub-word stores take the RMW path
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_err)                                   state_d = RESP;
        else if (bus.MemWrite && bus.Funct3 == 3'b010) state_d = WR;
        else                                           state_d = RD;
      end
      RD:      state_d = DATA;
      DATA:    state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: latch on accept, capture/merge in DATA, clear rdata for stores/errors
  always_comb begin
    f3_d        = f3_q;
    boff_d      = boff_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        f3_d    = bus.Funct3;
        boff_d  = bus.addr[1:0];
        wdata_d = bus.wdata;
        store_d = bus.MemWrite;
        err_d   = req_err;
        if (req_err) begin
          rdata_d = '0;
        end else begin
          // mem_addr only moves for requests that touch memory
          mem_addr_d  = {bus.addr[DM_ADDRESS-1:2], 2'b00};
          mem_wdata_d = bus.wdata;
        end
      end
      DATA: begin
        if (store_q) mem_wdata_d = merged;
        else         rdata_d     = load_ext;
      end
      WR:      rdata_d = '0;
      default: ;
    endcase
  end

  // State register; async reset returns to IDLE so mem_Wr drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q        <= '0;
      boff_q      <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      f3_q        <= f3_d;
      boff_q      <= boff_d;
      wdata_q     <= wdata_d;
      store_q     <= store_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Strobes decode straight from state so they never overlap
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_re     = (state_q == RD);
  assign bus.mem_Wr     = (state_q == WR) ? 4'b1111 : 4'b0000;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Bench for lsu_subword_rmw: word memory model plus a byte-arithmetic
// reference of load extension, store merge, legality and latency.
module tb_lsu_subword_rmw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] ref_mem [128];
  logic [31:0] mem     [128];
  logic [31:0] last_rd, last_wd;

  lsu_subword_rmw_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  lsu_subword_rmw #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory: read data one cycle after mem_re, whole-word writes
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    if (bus.mem_Wr == 4'hF) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One request; call at a negedge in IDLE, returns at the negedge of the following IDLE cycle
  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [8:0] a, input logic [31:0] wd);
    bit          e;
    int          sz, sh;
    longint unsigned m;
    logic [31:0] lm, old, val, exp_rd, exp_new;
    int          exp_resp, exp_re, exp_wr;
    int          re_at, wr_at, resp_at, re_n, wr_n;
    logic [31:0] got_wd, got_rd;
    logic        got_err, both;
    logic [8:0]  re_addr, wr_addr;
    logic [3:0]  got_wr;

    sz  = 1 << f3[1:0];
    sh  = 8 * (a % 4);
    m   = (64'd1 << (8 * sz)) - 1;
    lm  = 32'(m << sh);
    old = ref_mem[a[8:2]];
    e   = (rd && wr) || (rd && (f3 == 3 || f3 >= 6)) || (wr && f3 > 2) || ((a % sz) != 0);
    exp_rd = 0; exp_new = old; exp_re = 0; exp_wr = 0;
    if (e) begin
      exp_resp = 1;
    end else if (rd) begin
      val = (old >> sh) & 32'(m);
      if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~32'(m);
      exp_rd = val; exp_resp = 3; exp_re = 1;
    end else begin
      exp_new = (old & ~lm) | ((wd << sh) & lm);
      if (sz == 4) begin exp_resp = 2; exp_wr = 1; end
      else begin exp_resp = 4; exp_re = 1; exp_wr = 3; end
    end

    chk("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.MemRead = rd; bus.MemWrite = wr;
    bus.Funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    re_at = 0; wr_at = 0; resp_at = 0; re_n = 0; wr_n = 0; both = 0;
    got_wd = 0; got_rd = 0; got_err = 0; re_addr = 0; wr_addr = 0; got_wr = 0;
    for (int c = 1; c <= 8 && resp_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        bus.wdata = $urandom; bus.addr = 9'($urandom);
      end
      if (bus.mem_re) begin re_n++; re_at = c; re_addr = bus.mem_addr; end
      if (bus.mem_Wr != 0) begin
        wr_n++; wr_at = c; got_wr = bus.mem_Wr; got_wd = bus.mem_wdata; wr_addr = bus.mem_addr;
      end
      if (bus.mem_re && bus.mem_Wr != 0) both = 1;
      if (bus.resp_valid) begin resp_at = c; got_err = bus.resp_err; got_rd = bus.rdata; end
    end
    chk("resp_cycle", resp_at, exp_resp);
    chk("resp_err", 32'(got_err), 32'(e));
    chk("rdata", got_rd, exp_rd);
    chk("re_count", re_n, (exp_re != 0) ? 1 : 0);
    chk("re_cycle", re_at, exp_re);
    chk("wr_count", wr_n, (exp_wr != 0) ? 1 : 0);
    chk("wr_cycle", wr_at, exp_wr);
    chk("re_wr_overlap", 32'(both), 32'd0);
    if (exp_re != 0) chk("re_addr", 32'(re_addr), 32'({a[8:2], 2'b00}));
    if (exp_wr != 0) begin
      chk("wr_strobe", 32'(got_wr), 32'hF);
      chk("wr_addr", 32'(wr_addr), 32'({a[8:2], 2'b00}));
      chk("wr_data", got_wd, exp_new);
      ref_mem[a[8:2]] = exp_new;
    end
    last_rd = got_rd; last_wd = got_wd;
    @(negedge clk);
    chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] ld_ok [5];
    logic [2:0] f3;
    bit         rd, wr;
    int         r;
    ld_ok[0] = 3'b000; ld_ok[1] = 3'b001; ld_ok[2] = 3'b010; ld_ok[3] = 3'b100; ld_ok[4] = 3'b101;

    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    bus.req_valid = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.Funct3 = 0; bus.addr = 0; bus.wdata = 0;

    // reset values
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_Wr", 32'(bus.mem_Wr), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed steps from the plan
    txn(0, 1, 3'b010, 9'h010, 32'hDEADBEEF);
    chk("plan_sw_rdata", last_rd, 32'd0);
    txn(0, 1, 3'b010, 9'h010, 32'h80FF7F01);
    txn(1, 0, 3'b000, 9'h013, 32'h0);
    chk("plan_lb", last_rd, 32'hFFFFFF80);
    txn(1, 0, 3'b100, 9'h013, 32'h0);
    chk("plan_lbu", last_rd, 32'h00000080);
    txn(0, 1, 3'b010, 9'h010, 32'h11223344);
    txn(0, 1, 3'b000, 9'h011, 32'h000000AB);
    chk("plan_sb_merge", last_wd, 32'h1122AB44);
    txn(0, 1, 3'b010, 9'h010, 32'h11223344);
    txn(0, 1, 3'b001, 9'h012, 32'h0000CAFE);
    chk("plan_sh_merge", last_wd, 32'hCAFE3344);
    txn(1, 0, 3'b001, 9'h012, 32'h0);
    chk("plan_lh", last_rd, 32'hFFFFCAFE);
    txn(1, 0, 3'b010, 9'h006, 32'h0);
    txn(0, 1, 3'b001, 9'h005, 32'h1234);
    txn(1, 1, 3'b010, 9'h008, 32'h1);
    txn(1, 0, 3'b110, 9'h008, 32'h0);
    txn(0, 1, 3'b100, 9'h008, 32'h0);
    txn(1, 0, 3'b101, 9'h013, 32'h0);

    // request with neither MemRead nor MemWrite is ignored
    bus.req_valid = 1'b1; bus.Funct3 = 3'b010; bus.addr = 9'h010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ign_mem_re", 32'(bus.mem_re), 32'd0);
      chk("ign_resp", 32'(bus.resp_valid), 32'd0);
      chk("ign_ready", 32'(bus.req_ready), 32'd1);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);

    // reset during the RD of an SB aborts with no write and no response
    txn(0, 1, 3'b010, 9'h020, 32'h55667788);
    bus.req_valid = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = 3'b000;
    bus.addr = 9'h021; bus.wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.MemWrite = 1'b0;
    chk("abort_in_rd", 32'(bus.mem_re), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready_async", 32'(bus.req_ready), 32'd1);
    chk("abort_re_async", 32'(bus.mem_re), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      chk("abort_no_wr", 32'(bus.mem_Wr), 32'd0);
      chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
    end
    txn(1, 0, 3'b010, 9'h020, 32'h0);
    chk("abort_word_kept", last_rd, 32'h55667788);

    // randomized requests against the reference
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 19);
      rd = (r < 9) || (r == 19);
      wr = (r >= 9);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd && !wr)            f3 = ld_ok[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom_range(0, 2));
      txn(rd, wr, f3, 9'($urandom_range(0, 63)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
